// File: rtl/trace_scan_sequencer.sv
// trace_scan_sequencer
//
// Walks a COLS x ROWS raster and hands one trace request per pixel to the
// ray tracer. Up to MAX_OUT requests may be in flight at once. Tracer
// results come back in issue order and are written to the frame buffer at
// the matching pixel address, while their hit flags are OR-ed into a
// per-frame summary. Runs one frame per start, or back-to-back frames while
// continuous is held high.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. While req_valid is high and req_ready is low,
// req_col/req_row hold their values. req_valid never depends on req_ready.
// Responses (resp_valid) have no backpressure and are taken on any edge
// where resp_valid is high.
//
// Ports
//   tracer_clk   clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   start        begin frame(s); only looked at while idle
//   continuous   restart after each frame; looked at when a frame ends
//   busy         high whenever the sequencer is not idle
//   req_valid    trace request valid
//   req_ready    tracer accepts the request
//   req_col      request column
//   req_row      request row
//   resp_valid   tracer result valid
//   resp_data    pixel colour
//   resp_hit     per-pixel hit flags
//   fb_we        frame buffer write strobe
//   fb_addr      frame buffer address {row, col}
//   fb_data      frame buffer write data (registered resp_data)
//   frame_done   one-cycle pulse when the last pixel of a frame is written
//   frame_hits   OR of resp_hit over the last completed frame
//   resp_err     sticky: a response arrived with nothing outstanding
//   state_dbg    current FSM state (0 idle, 1 issue, 2 drain)

module trace_scan_sequencer #(
    parameter int COL_W   = 7,
    parameter int ROW_W   = 6,
    parameter int COLS    = 128,
    parameter int ROWS    = 64,
    parameter int DATA_W  = 12,
    parameter int HIT_W   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                   tracer_clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   continuous,
    output logic                   busy,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [COL_W-1:0]       req_col,
    output logic [ROW_W-1:0]       req_row,
    input  logic                   resp_valid,
    input  logic [DATA_W-1:0]      resp_data,
    input  logic [HIT_W-1:0]       resp_hit,
    output logic                   fb_we,
    output logic [ROW_W+COL_W-1:0] fb_addr,
    output logic [DATA_W-1:0]      fb_data,
    output logic                   frame_done,
    output logic [HIT_W-1:0]       frame_hits,
    output logic                   resp_err,
    output logic [1:0]             state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [3:0]       MAX_CNT  = 4'(MAX_OUT);

    logic [1:0]       state;
    logic [3:0]       outstanding;
    logic [COL_W-1:0] iss_col;
    logic [ROW_W-1:0] iss_row;
    logic [COL_W-1:0] wr_col;
    logic [ROW_W-1:0] wr_row;
    logic [HIT_W-1:0] hit_acc;

    logic req_fire;
    logic resp_accept;
    logic last_issue;
    logic frame_end;

    assign busy      = (state != S_IDLE);
    assign req_valid = (state == S_ISSUE) && (outstanding < MAX_CNT);
    assign req_col   = iss_col;
    assign req_row   = iss_row;
    assign state_dbg = state;

    assign req_fire    = req_valid && req_ready;
    // A response with nothing in flight cannot belong to any request.
    assign resp_accept = resp_valid && (outstanding != 4'd0);
    assign last_issue  = (iss_col == LAST_COL) && (iss_row == LAST_ROW);
    // Once in DRAIN no new requests go out, so the response that takes the
    // count from 1 to 0 is the last pixel of the frame.
    assign frame_end   = (state == S_DRAIN) && resp_accept && (outstanding == 4'd1);

    always_ff @(posedge tracer_clk) begin
        if (rst) begin
            state       <= S_IDLE;
            outstanding <= 4'd0;
            iss_col     <= '0;
            iss_row     <= '0;
            wr_col      <= '0;
            wr_row      <= '0;
            hit_acc     <= '0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
            frame_done  <= 1'b0;
            frame_hits  <= '0;
            resp_err    <= 1'b0;
        end else begin
            fb_we      <= resp_accept;
            frame_done <= frame_end;

            if (resp_valid && (outstanding == 4'd0)) begin
                resp_err <= 1'b1;
            end

            if (resp_accept) begin
                fb_addr <= {wr_row, wr_col};
                fb_data <= resp_data;
                hit_acc <= hit_acc | resp_hit;
                if (wr_col == LAST_COL) begin
                    wr_col <= '0;
                    wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + ROW_W'(1);
                end else begin
                    wr_col <= wr_col + COL_W'(1);
                end
            end

            if (frame_end) begin
                frame_hits <= hit_acc | resp_hit;
            end

            // Simultaneous issue and return leave the count unchanged.
            if (req_fire && !resp_accept) begin
                outstanding <= outstanding + 4'd1;
            end else if (!req_fire && resp_accept) begin
                outstanding <= outstanding - 4'd1;
            end

            if (req_fire) begin
                if (iss_col == LAST_COL) begin
                    iss_col <= '0;
                    iss_row <= (iss_row == LAST_ROW) ? '0 : iss_row + ROW_W'(1);
                end else begin
                    iss_col <= iss_col + COL_W'(1);
                end
            end

            // Frame entry clears run after the datapath updates so they win.
            // No response can be accepted on these edges: outstanding is 0.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_ISSUE;
                        iss_col <= '0;
                        iss_row <= '0;
                        wr_col  <= '0;
                        wr_row  <= '0;
                        hit_acc <= '0;
                    end
                end
                S_ISSUE: begin
                    if (req_fire && last_issue) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Reached one cycle after frame_end, so the next frame's
                    // first request follows frame_done by one cycle.
                    if (outstanding == 4'd0) begin
                        if (continuous) begin
                            state   <= S_ISSUE;
                            iss_col <= '0;
                            iss_row <= '0;
                            wr_col  <= '0;
                            wr_row  <= '0;
                            hit_acc <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_scan_sequencer.sv
// Bench for trace_scan_sequencer on a 4 x 2 raster with two credits.
// A tracer model answers every request after a fixed latency; a raster
// reference (pixel index arithmetic) predicts every request, write, hit
// summary and frame boundary.

module tb_trace_scan_sequencer;

    localparam int COL_W   = 2;
    localparam int ROW_W   = 1;
    localparam int COLS    = 4;
    localparam int ROWS    = 2;
    localparam int DATA_W  = 12;
    localparam int HIT_W   = 4;
    localparam int MAX_OUT = 2;
    localparam int NPIX    = COLS * ROWS;
    localparam int AW      = ROW_W + COL_W;

    // ---------------- clock / reset / DUT ----------------
    logic                tracer_clk = 1'b0;
    logic                rst, start, continuous;
    logic                busy, req_valid, req_ready;
    logic [COL_W-1:0]    req_col;
    logic [ROW_W-1:0]    req_row;
    logic                resp_valid;
    logic [DATA_W-1:0]   resp_data;
    logic [HIT_W-1:0]    resp_hit;
    logic                fb_we;
    logic [AW-1:0]       fb_addr;
    logic [DATA_W-1:0]   fb_data;
    logic                frame_done;
    logic [HIT_W-1:0]    frame_hits;
    logic                resp_err;
    logic [1:0]          state_dbg;

    always #5 tracer_clk = ~tracer_clk;

    trace_scan_sequencer #(
        .COL_W(COL_W), .ROW_W(ROW_W), .COLS(COLS), .ROWS(ROWS),
        .DATA_W(DATA_W), .HIT_W(HIT_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .tracer_clk(tracer_clk), .rst(rst), .start(start), .continuous(continuous),
        .busy(busy), .req_valid(req_valid), .req_ready(req_ready),
        .req_col(req_col), .req_row(req_row),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .frame_done(frame_done), .frame_hits(frame_hits), .resp_err(resp_err),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stimulus knobs owned by the main sequence, read by the tracer.
    bit               throttle = 1'b0;
    int               lat      = 3;
    int               hit_pix  = 0;
    logic [HIT_W-1:0] hit_tab[4];
    int               stray_req = 0;

    // Tracer / reference state.
    typedef struct {
        int idx;
        int due;
    } pend_t;

    pend_t                   pend_q[$];
    logic [AW+DATA_W-1:0]    exp_q[$];
    int                      cyc         = 0;
    int                      model_out   = 0;
    int                      req_idx     = 0;
    int                      frame_reqs  = 0;
    int                      resp_frames = 0;
    int                      done_seen   = 0;
    int                      stray_done  = 0;
    bit                      in_drain, pend_we, pend_done, exp_err;
    bit                      check_after, done_mode, prev_stall;
    logic [HIT_W-1:0]        acc, exp_fh;
    logic [COL_W-1:0]        prev_col;
    logic [ROW_W-1:0]        prev_row;

    function automatic logic [AW-1:0] pix_addr(input int idx);
        return AW'(((idx / COLS) << COL_W) + (idx % COLS));
    endfunction

    task automatic model_clear();
        pend_q.delete();
        exp_q.delete();
        model_out   = 0;
        req_idx     = 0;
        frame_reqs  = 0;
        in_drain    = 1'b0;
        pend_we     = 1'b0;
        pend_done   = 1'b0;
        exp_err     = 1'b0;
        check_after = 1'b0;
        prev_stall  = 1'b0;
        acc         = '0;
        exp_fh      = '0;
        stray_done  = stray_req;
    endtask

    // ---------------- tracer model + per-cycle scoreboard ----------------
    initial begin : tracer
        bit                   hs;
        pend_t                p;
        logic [AW+DATA_W-1:0] e;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_hit   = '0;
        model_clear();
        forever begin
            @(negedge tracer_clk);
            cyc++;
            if (rst) begin
                model_clear();
                req_ready  = 1'b0;
                resp_valid = 1'b0;
                resp_data  = '0;
                resp_hit   = '0;
                continue;
            end

            // Outputs produced by the previous edge.
            chk_eq("fb_we", 32'(fb_we), 32'(pend_we));
            if (fb_we) begin
                if (exp_q.size() == 0) begin
                    chk_eq("fb_write_unexpected", 32'(fb_addr), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("fb_addr", 32'(fb_addr), 32'(e[AW+DATA_W-1:DATA_W]));
                    chk_eq("fb_data", 32'(fb_data), 32'(e[DATA_W-1:0]));
                end
            end
            chk_eq("resp_err", 32'(resp_err), 32'(exp_err));
            chk_eq("frame_done", 32'(frame_done), 32'(pend_done));
            chk_eq("frame_hits", 32'(frame_hits), 32'(exp_fh));
            if (check_after) begin
                chk_eq("busy_after_done", 32'(busy), 32'(done_mode));
                check_after = 1'b0;
            end
            chk_eq("req_valid", 32'(req_valid),
                   32'(busy && !in_drain && (model_out < MAX_OUT)));
            if (prev_stall) begin
                chk_eq("hold_col", 32'(req_col), 32'(prev_col));
                chk_eq("hold_row", 32'(req_row), 32'(prev_row));
            end
            if (frame_done) begin
                chk_eq("reqs_per_frame", 32'(frame_reqs), 32'(NPIX));
                frame_reqs  = 0;
                done_seen++;
                done_mode   = continuous;
                check_after = 1'b1;
                in_drain    = 1'b0;
            end

            // Drive the next edge.
            pend_we   = 1'b0;
            pend_done = 1'b0;
            req_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            hs         = req_valid && req_ready;
            prev_stall = req_valid && !req_ready;
            prev_col   = req_col;
            prev_row   = req_row;
            if (hs) begin
                chk_eq("req_col", 32'(req_col), 32'(req_idx % COLS));
                chk_eq("req_row", 32'(req_row), 32'(req_idx / COLS));
                chk_eq("req_in_drain", 32'(in_drain), 32'(0));
                pend_q.push_back('{idx: req_idx, due: cyc + lat});
                frame_reqs++;
                model_out++;
                if (req_idx == NPIX - 1) begin
                    in_drain = 1'b1;
                    req_idx  = 0;
                end else begin
                    req_idx++;
                end
            end

            resp_valid = 1'b0;
            resp_hit   = '0;
            if (stray_done != stray_req) begin
                stray_done++;
                resp_valid = 1'b1;
                resp_data  = DATA_W'($urandom);
                resp_hit   = 4'b1111;
                if (model_out == 0) exp_err = 1'b1;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p          = pend_q.pop_front();
                resp_valid = 1'b1;
                resp_data  = DATA_W'($urandom);
                resp_hit   = (p.idx == hit_pix) ? hit_tab[resp_frames % 4] : '0;
                exp_q.push_back({pix_addr(p.idx), resp_data});
                pend_we = 1'b1;
                acc     = acc | resp_hit;
                model_out--;
                if (p.idx == NPIX - 1) begin
                    exp_fh    = acc;
                    acc       = '0;
                    pend_done = 1'b1;
                    resp_frames++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_values(input string tag);
        chk_eq({tag, "_busy"},       32'(busy),       32'(0));
        chk_eq({tag, "_req_valid"},  32'(req_valid),  32'(0));
        chk_eq({tag, "_req_col"},    32'(req_col),    32'(0));
        chk_eq({tag, "_req_row"},    32'(req_row),    32'(0));
        chk_eq({tag, "_fb_we"},      32'(fb_we),      32'(0));
        chk_eq({tag, "_fb_addr"},    32'(fb_addr),    32'(0));
        chk_eq({tag, "_fb_data"},    32'(fb_data),    32'(0));
        chk_eq({tag, "_frame_done"}, 32'(frame_done), 32'(0));
        chk_eq({tag, "_frame_hits"}, 32'(frame_hits), 32'(0));
        chk_eq({tag, "_resp_err"},   32'(resp_err),   32'(0));
    endtask

    task automatic start_pulse();
        @(negedge tracer_clk);
        start = 1'b1;
        @(negedge tracer_clk);
        start = 1'b0;
        chk_eq("start_busy",      32'(busy),      32'(1));
        chk_eq("start_req_valid", 32'(req_valid), 32'(1));
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_seen < target && n < 2000) begin
            @(negedge tracer_clk);
            n++;
        end
        chk_eq(name, 32'(done_seen), 32'(target));
    endtask

    typedef struct {
        bit               throttle;
        int               lat;
        int               hit_pix;
        logic [HIT_W-1:0] hit;
        logic [HIT_W-1:0] exp_hits;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int base;
        base     = done_seen;
        throttle = v.throttle;
        lat      = v.lat;
        hit_pix  = v.hit_pix;
        for (int k = 0; k < 4; k++) hit_tab[k] = v.hit;
        start_pulse();
        wait_done(base + 1, "vec_frame_done");
        chk_eq("vec_frame_hits", 32'(frame_hits), 32'(v.exp_hits));
        repeat (2) @(negedge tracer_clk);
        chk_eq("vec_idle_after", 32'(busy), 32'(0));
        chk_eq("vec_one_done", 32'(done_seen), 32'(base + 1));
    endtask

    // ---------------- main sequence ----------------
    initial begin : main_seq
        vec_t vecs[6];
        int   base;
        int   n;
        int   r;

        vecs[0] = '{throttle: 1'b0, lat: 3, hit_pix: 0, hit: 4'b0000, exp_hits: 4'b0000};
        vecs[1] = '{throttle: 1'b0, lat: 3, hit_pix: 7, hit: 4'b0100, exp_hits: 4'b0100};
        vecs[2] = '{throttle: 1'b1, lat: 3, hit_pix: 3, hit: 4'b0011, exp_hits: 4'b0011};
        vecs[3] = '{throttle: 1'b1, lat: 1, hit_pix: 5, hit: 4'b1001, exp_hits: 4'b1001};
        vecs[4] = '{throttle: 1'b0, lat: 1, hit_pix: 0, hit: 4'b1111, exp_hits: 4'b1111};
        vecs[5] = '{throttle: 1'b1, lat: 2, hit_pix: 4, hit: 4'b0110, exp_hits: 4'b0110};

        for (int k = 0; k < 4; k++) hit_tab[k] = '0;
        rst        = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        repeat (3) @(negedge tracer_clk);
        check_reset_values("por");
        rst = 1'b0;

        // Single-shot frames from the vector table.
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Continuous for two frames, dropped during the third.
        base     = done_seen;
        throttle = 1'b1;
        lat      = 3;
        hit_pix  = 2;
        r        = resp_frames;
        hit_tab[r % 4]       = 4'b0001;
        hit_tab[(r + 1) % 4] = 4'b1000;
        hit_tab[(r + 2) % 4] = 4'b0000;
        hit_tab[(r + 3) % 4] = 4'b0000;
        continuous = 1'b1;
        start_pulse();
        wait_done(base + 1, "cont_frame1");
        chk_eq("cont_hits1", 32'(frame_hits), 32'(4'b0001));
        @(negedge tracer_clk);
        start = 1'b1;                       // must be ignored while busy
        @(negedge tracer_clk);
        start = 1'b0;
        wait_done(base + 2, "cont_frame2");
        chk_eq("cont_hits2", 32'(frame_hits), 32'(4'b1000));
        repeat (3) @(negedge tracer_clk);
        continuous = 1'b0;
        wait_done(base + 3, "cont_frame3");
        chk_eq("cont_hits3", 32'(frame_hits), 32'(4'b0000));
        repeat (2) @(negedge tracer_clk);
        chk_eq("cont_idle", 32'(busy), 32'(0));
        chk_eq("cont_frames", 32'(done_seen), 32'(base + 3));

        // Stray response while idle.
        @(negedge tracer_clk);
        stray_req++;
        repeat (3) @(negedge tracer_clk);
        chk_eq("stray_err", 32'(resp_err), 32'(1));
        chk_eq("stray_no_write", 32'(fb_we), 32'(0));
        run_vec(vecs[0]);
        chk_eq("stray_err_sticky", 32'(resp_err), 32'(1));

        // Reset in the middle of issuing with two requests in flight.
        throttle = 1'b0;
        lat      = 3;
        start_pulse();
        n = 0;
        while (model_out != 2 && n < 50) begin
            @(negedge tracer_clk);
            n++;
        end
        chk_eq("two_outstanding", 32'(model_out), 32'(2));
        rst = 1'b1;
        @(negedge tracer_clk);
        check_reset_values("mid_rst");
        @(negedge tracer_clk);
        rst = 1'b0;
        run_vec(vecs[1]);

        repeat (4) @(negedge tracer_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
